// File: rtl/seq_timing_pkg.sv
// Shared phase-window constants and Johnson-code helpers for the master sequencer.
package seq_timing_pkg;

  localparam int unsigned RAS_CPU_FIRST = 3;
  localparam int unsigned RAS_CPU_LAST  = 6;
  localparam int unsigned RAS_VID_FIRST = 11;
  localparam int unsigned RAS_VID_LAST  = 14;
  localparam int unsigned VID_FIRST     = 8;
  localparam int unsigned READY_FIRST   = 12;
  localparam int unsigned LOAD_PHASE    = 15;

  // Strobe bundle produced by the phase decoder.
  typedef struct packed {
    logic phi_n;
    logic cclk;
    logic ras_n;
    logic vid_sel;
    logic ready;
    logic load;
  } strobe_t;

  // Filling half (bit7 clear): phase = number of ones.
  // Draining half (bit7 set): phase = 8 + number of zeros.
  function automatic logic [3:0] johnson_to_phase(input logic [7:0] s);
    logic [3:0] ones;
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + {3'd0, s[i]};
    if (!s[7] || (ones == 4'd8)) return ones;
    return 4'd8 + (4'd8 - ones);
  endfunction

  // Legal Johnson codes have at most one boundary between adjacent bits.
  function automatic logic johnson_valid(input logic [7:0] s);
    logic [2:0] edges;
    edges = '0;
    for (int i = 0; i < 7; i++) edges = edges + {2'd0, s[i] ^ s[i+1]};
    return (edges <= 3'd1);
  endfunction

endpackage

// File: rtl/seq_timing_decode.sv
// Combinational map from a 4-bit phase index to the six system strobes.
module seq_phase_decode
  import seq_timing_pkg::*;
(
  input  logic [3:0] p,
  output strobe_t    strb
);

  // Window compares against the package phase constants.
  always_comb begin
    strb         = '0;
    strb.phi_n   = p[1];
    strb.cclk    = ~p[3];
    strb.ras_n   = ~(((32'(p) >= RAS_CPU_FIRST) && (32'(p) <= RAS_CPU_LAST)) ||
                     ((32'(p) >= RAS_VID_FIRST) && (32'(p) <= RAS_VID_LAST)));
    strb.vid_sel = (32'(p) >= VID_FIRST);
    strb.ready   = (32'(p) >= READY_FIRST);
    strb.load    = (32'(p) == LOAD_PHASE);
  end

endmodule

// File: rtl/seq_timing.sv
// Master timing sequencer: 8-bit Johnson counter plus registered strobes
// decoded from the next phase so every output lines up with the S it sits beside.
module seq_timing
  import seq_timing_pkg::*;
(
  input  logic       CLK_n,
  input  logic       RESET_n,
  output logic [7:0] S,
  output logic [3:0] PHASE,
  output logic       PHI_n,
  output logic       CCLK,
  output logic       RAS_n,
  output logic       VID_SEL,
  output logic       READY,
  output logic       LOAD
);

  logic [7:0] s_q;
  logic [7:0] s_nxt;
  logic [3:0] p_q;
  logic [3:0] p_nxt;
  strobe_t    strb_nxt;
  strobe_t    strb_q;
  logic       legal;

  // Next state: shift on a legal code, otherwise fall back to phase 0.
  always_comb begin
    legal = johnson_valid(s_q);
    s_nxt = 8'h00;
    p_nxt = 4'd0;
    if (legal) begin
      s_nxt = {s_q[6:0], ~s_q[7]};
      p_nxt = johnson_to_phase(s_q) + 4'd1;
    end
  end

  seq_phase_decode u_dec (
    .p    (p_nxt),
    .strb (strb_nxt)
  );

  // State, phase and strobe registers; reset lands on decode(0).
  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      s_q            <= 8'h00;
      p_q            <= 4'd0;
      strb_q         <= '0;
      strb_q.cclk    <= 1'b1;
      strb_q.ras_n   <= 1'b1;
    end else begin
      s_q    <= s_nxt;
      p_q    <= p_nxt;
      strb_q <= strb_nxt;
    end
  end

  assign S       = s_q;
  assign PHASE   = p_q;
  assign PHI_n   = strb_q.phi_n;
  assign CCLK    = strb_q.cclk;
  assign RAS_n   = strb_q.ras_n;
  assign VID_SEL = strb_q.vid_sel;
  assign READY   = strb_q.ready;
  assign LOAD    = strb_q.load;

endmodule

// File: tb/tb_seq_timing.sv
// Directed bench for seq_timing: hand tables of S and strobes per phase.
module tb_seq_timing;

  logic       CLK_n;
  logic       RESET_n;
  logic [7:0] S;
  logic [3:0] PHASE;
  logic       PHI_n, CCLK, RAS_n, VID_SEL, READY, LOAD;

  int errs   = 0;
  int checks = 0;

  seq_timing dut (
    .CLK_n   (CLK_n),
    .RESET_n (RESET_n),
    .S       (S),
    .PHASE   (PHASE),
    .PHI_n   (PHI_n),
    .CCLK    (CCLK),
    .RAS_n   (RAS_n),
    .VID_SEL (VID_SEL),
    .READY   (READY),
    .LOAD    (LOAD)
  );

  initial CLK_n = 1'b0;
  always #5 CLK_n = ~CLK_n;

  // Hand-written expected values, bit p of each mask = strobe at phase p.
  logic [7:0]  s_tab [16];
  logic [15:0] m_phi, m_cclk, m_ras, m_vid, m_rdy, m_load;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic chk_phase(input string tag, input int p);
    chk({tag, ".S"},       32'(S),       32'(s_tab[p]));
    chk({tag, ".PHASE"},   32'(PHASE),   32'(p));
    chk({tag, ".PHI_n"},   32'(PHI_n),   32'(m_phi[p]));
    chk({tag, ".CCLK"},    32'(CCLK),    32'(m_cclk[p]));
    chk({tag, ".RAS_n"},   32'(RAS_n),   32'(m_ras[p]));
    chk({tag, ".VID_SEL"}, 32'(VID_SEL), 32'(m_vid[p]));
    chk({tag, ".READY"},   32'(READY),   32'(m_rdy[p]));
    chk({tag, ".LOAD"},    32'(LOAD),    32'(m_load[p]));
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLK_n);
  endtask

  initial begin
    int  cclk_rises, ras_pulses, ras_len, load_pulses, p;
    logic prev_cclk, prev_ras;

    s_tab = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
              8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    m_phi  = 16'hCCCC;
    m_cclk = 16'h00FF;
    m_ras  = 16'h8787;
    m_vid  = 16'hFF00;
    m_rdy  = 16'hF000;
    m_load = 16'h8000;

    // Reset held across a few edges.
    RESET_n = 1'b0;
    step(3);
    chk_phase("reset", 0);

    // 64 edges from phase 0, checking decode every cycle.
    RESET_n = 1'b1;
    cclk_rises = 0; ras_pulses = 0; ras_len = 0; load_pulses = 0;
    prev_cclk = CCLK; prev_ras = RAS_n;
    for (int k = 1; k <= 64; k++) begin
      step(1);
      p = k % 16;
      chk_phase("run", p);
      if (CCLK && !prev_cclk) cclk_rises++;
      if (!RAS_n) ras_len++;
      if (RAS_n && !prev_ras) begin
        ras_pulses++;
        chk("ras_len", 32'(ras_len), 32'd4);
        ras_len = 0;
      end
      if (LOAD) begin
        load_pulses++;
        chk("load_at_80", 32'(S), 32'h80);
      end
      prev_cclk = CCLK; prev_ras = RAS_n;
    end
    chk("cclk_rises",  32'(cclk_rises),  32'd4);
    chk("ras_pulses",  32'(ras_pulses),  32'd8);
    chk("load_pulses", 32'(load_pulses), 32'd4);

    // Illegal code deposited at phase 6 recovers to phase 0 in one edge.
    step(6);
    chk_phase("pre_dep", 6);
    force dut.s_q = 8'h5A;
    #1 release dut.s_q;
    step(1);
    chk_phase("recover", 0);
    step(1);
    chk_phase("after_rec", 1);

    // Asynchronous reset at phase 12, between edges.
    step(11);
    chk_phase("pre_rst", 12);
    #2 RESET_n = 1'b0;
    #1 chk_phase("async_rst", 0);
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk_phase("rst_hold", 0);
    end
    RESET_n = 1'b1;
    step(1);
    chk_phase("rst_rel", 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/seq_timing.md
# seq_timing

Master timing sequencer for the gate array. An 8-bit Johnson counter clocked at 16 MHz produces the sequencer state S[7:0], with 16 phases per 1 µs cycle. The block also derives the registered system strobes from the phase: the 4 MHz CPU clock, the 1 MHz CCLK, RAS_n, the address-mux select, CPU READY and the video latch strobe. S and PHI_n feed the downstream CAS generator directly.

## Interface
Parameters:
- none; all phase windows are package constants.

Ports:
- CLK_n  in  1  16 MHz master clock; all state updates on its rising edge.
- RESET_n  in  1  asynchronous, active-low reset.
- S  out  8  Johnson sequencer state.
- PHASE  out  4  binary phase index 0..15 of S.
- PHI_n  out  1  4 MHz CPU clock, inverted.
- CCLK  out  1  1 MHz clock for CRTC/PSG.
- RAS_n  out  1  DRAM row strobe.
- VID_SEL  out  1  address mux: 1 = video address, 0 = CPU address.
- READY  out  1  1 = CPU wait released.
- LOAD  out  1  one-cycle video data latch strobe.

## Operation
- Phase encoding:
  - p = 0..8: S has p ones filled from bit 0 (p=0 → 0x00, p=8 → 0xFF).
  - p = 9..15: S = 0xFF shifted left by (p−8), giving 0xFE … 0x80.
- Advance: each CLK_n rising edge, S ← {S[6:0], ~S[7]}, so p ← (p+1) mod 16.
- Validity: S is legal iff at most one i in 0..6 has S[i] ≠ S[i+1].
  - Illegal S loads 0x00 on the next edge, not the shifted value.
  - All outputs then take decode(0).
  - Recovery completes in exactly one edge.
- Decode(p), output values:
  - PHI_n = p[1].
  - CCLK = 1 for p 0..7.
  - RAS_n = 0 for p 3..6 (CPU) and p 11..14 (video); 1 otherwise.
  - VID_SEL = 1 for p 8..15.
  - READY = 1 for p 12..15.
  - LOAD = 1 only at p = 15.
- PHASE is the binary p; it is registered alongside S.
- All outputs are registers loaded from decode(next p). Every output therefore matches the S value it is presented with; no combinational output paths.
- Reset, asserted: S = 0x00, PHASE = 0, and outputs = decode(0):
  - PHI_n = 0, CCLK = 1, RAS_n = 1.
  - VID_SEL = 0, READY = 0, LOAD = 0.
- Reset mid-cycle: outputs go to the reset values immediately, with no clock required.

## Timing
- Period: 16 CLK_n cycles = 1 µs at 16 MHz.
- First edge after RESET_n deasserts: p = 1, S = 0x01.
- PHI_n: period 4 cycles, 50 % duty. Low at p mod 4 ∈ {0,1}, high at {2,3}.
- CCLK: 8 cycles high, 8 cycles low, rising at the 15→0 transition.
- RAS_n: two 4-cycle low pulses per µs, separated by 4-cycle high gaps.
  - Each pulse falls 3 cycles after its half-cycle boundary.
  - The VID_SEL edge always precedes the RAS_n fall by 3 cycles.
- READY: 4-cycle window ending at the wrap; its rising edge lands at p = 12.
- LOAD: a single 1-cycle pulse per µs, coincident with S = 0x80.
- Latency: zero cycles from S to the outputs (same register stage); one cycle from illegal S to recovery.
- RESET_n release coincident with a CLK_n edge: that edge is ignored and the state holds 0x00. The bench must not test this race.

## Structure
- Package seq_timing_pkg contains:
  - Phase window constants: RAS_CPU_FIRST=3, RAS_CPU_LAST=6, RAS_VID_FIRST=11, RAS_VID_LAST=14, VID_FIRST=8, READY_FIRST=12, LOAD_PHASE=15.
  - Function johnson_to_phase(S) → 4-bit.
  - Function johnson_valid(S) → 1-bit.
- Sub-module seq_phase_decode: a purely combinational map from 4-bit p to the six strobes, instantiated on the next-phase value.
- The top level holds the Johnson register, validity check, PHASE register and output registers.

## Test plan
- Reset, then 32 edges: S sequence 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00 and repeat. PHASE counts 1..15,0.
- Over 64 edges: PHI_n toggles every 2 edges. CCLK shows exactly 4 rising edges. RAS_n shows 8 low pulses, each 4 cycles. LOAD shows 4 single-cycle pulses, only at S=0x80.
- Per µs: RAS_n low with VID_SEL=0 at p 3..6, and with VID_SEL=1 at p 11..14. READY=1 exactly at p 12..15. Check against a reference decode every cycle.
- Deposit S=0x5A at p=6: the next edge gives S=0x00, PHASE=0 and decode(0) outputs. The following edge gives S=0x01.
- Assert RESET_n low at p=12 between edges: all outputs go to the reset values immediately. They hold across 5 edges while low. After release, the first edge gives S=0x01.
